mem_access_unit: RTL

- Consumer end of the decoder's memory-control interface.
- Takes the 2-bit MemRead/Memwrite size codes (01 byte, 10 half, 11 word), the ALU address and the store data.
- Performs the access against a word-wide data memory that has no byte enables and uses a req/ack handshake.
- Sub-word stores use read-modify-write; loads return sign-extended data. busy stalls the pipeline for the whole access.

---
 rtl/mem_pkg.sv | 47 ++++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_lane.sv | 48 ++++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit and the control decoder:
// access-size codes, load/store opcodes, FSM state encoding and the
// latched request record.
package mem_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [5:0] LB = 6'd32;
  localparam logic [5:0] LH = 6'd33;
  localparam logic [5:0] LW = 6'd35;
  localparam logic [5:0] SB = 6'd40;
  localparam logic [5:0] SH = 6'd41;
  localparam logic [5:0] SW = 6'd43;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR,
    FIN
  } state_t;

  // Everything about the accepted request that is needed after start drops.
  typedef struct packed {
    logic        is_store;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } req_t;

  // Opcode to {MemRead, Memwrite} size codes, as the control decoder emits them.
  function automatic logic [3:0] sizes_from_opcode(input logic [5:0] op);
    case (op)
      LB:      return {SZ_BYTE, SZ_NONE};
      LH:      return {SZ_HALF, SZ_NONE};
      LW:      return {SZ_WORD, SZ_NONE};
      SB:      return {SZ_NONE, SZ_BYTE};
      SH:      return {SZ_NONE, SZ_HALF};
      SW:      return {SZ_NONE, SZ_WORD};
      default: return {SZ_NONE, SZ_NONE};
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide data memory port with req/ack handshake. The access unit is the
// master; the memory (or its model) is the slave. mem_rdata is valid in the
// cycle mem_ack is high.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access_unit_lane.sv
// mem_lane_align: purely combinational byte-lane handling for a little-endian
// word memory. Extracts and sign-extends the addressed byte/half of a read
// word, and splices store data into the addressed lane of a word for RMW.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] load_word,
  input  logic [31:0] base_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = load_word[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? load_word[31:16] : load_word[15:0];

  // Load path: select the lane and sign-extend to 32 bits.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    load_val = load_word;
    case (size)
      SZ_BYTE: load_val = {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_val = {{16{ld_half[15]}}, ld_half};
      default: load_val = load_word;
    endcase
  end

  // Store path: overwrite only the addressed lane of the word read back.
  always_comb begin
    merged = base_word;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8] = store_data[7:0];
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = store_data[15:0];
        else         merged[15:0]  = store_data[15:0];
      end
      SZ_WORD: merged = store_data;
      default: merged = base_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: executes one load or store against a word-wide memory
// without byte enables. Sub-word stores are done as read-modify-write; loads
// return sign-extended data. busy stalls the pipeline for the whole access.
// Optional build macro MISALIGN_TRAP_EN: misaligned lh/sh/lw/sw raise err
// instead of being forced to the enclosing aligned word.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        MemRead,
  input  logic [1:0]        Memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  mem_access_unit_if.master mem
);

  state_t            state_q, state_d;
  req_t              req_q;
  logic [7:0]        tmo_q;
  logic [31:0]       rd_word_q, rdata_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  logic              accept, illegal, misalign, launch, launch_err;
  logic              abort, tmo_hit;
  logic [1:0]        req_size;
  logic [31:0]       load_val, merged;

  // Request decode. busy is low in IDLE and FIN, so a start in either is taken.
  assign req_size = (MemRead != SZ_NONE) ? MemRead : Memwrite;
  assign accept   = start && (state_q == IDLE || state_q == FIN);
  assign illegal  = (MemRead != SZ_NONE) && (Memwrite != SZ_NONE);
`ifdef MISALIGN_TRAP_EN
  assign misalign = (req_size == SZ_HALF && addr[0]) ||
                    (req_size == SZ_WORD && addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign launch_err = accept && (illegal || misalign);
  assign launch     = accept && !illegal && !misalign && (req_size != SZ_NONE);
  assign tmo_hit    = (tmo_q == 8'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and timeout abort decision.
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (launch) state_d = (Memwrite == SZ_WORD) ? WR : RD;
      end
      RD: begin
        if (mem.ack) begin
          state_d = req_q.is_store ? MERGE : FIN;
        end else if (tmo_hit) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      MERGE: state_d = WR;
      WR: begin
        if (mem.ack) begin
          state_d = FIN;
        end else if (tmo_hit) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: request latch, read capture, write word, timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_word_q <= '0;
      rdata_q   <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= launch_err || abort;
      // Clears outside RD/WR, so it restarts from zero on every entry.
      tmo_q <= (mem.req && !mem.ack) ? tmo_q + 8'd1 : 8'd0;
      if (launch) begin
        req_q  <= '{is_store: (Memwrite != SZ_NONE), size: req_size,
                    lane: addr[1:0], wdata: wdata};
        addr_q <= {addr[ADDR_W-1:2], 2'b00};
        if (Memwrite == SZ_WORD) wdata_q <= wdata;
      end
      if (state_q == RD && mem.ack) begin
        rd_word_q <= mem.rdata;
        if (!req_q.is_store) rdata_q <= load_val;
      end
      if (state_q == MERGE) wdata_q <= merged;
    end
  end

  mem_lane_align u_align (
    .size       (req_q.size),
    .lane       (req_q.lane),
    .load_word  (mem.rdata),
    .base_word  (rd_word_q),
    .store_data (req_q.wdata),
    .load_val   (load_val),
    .merged     (merged)
  );

  assign busy      = (state_q == RD) || (state_q == MERGE) || (state_q == WR);
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem.req   = (state_q == RD) || (state_q == WR);
  assign mem.we    = (state_q == WR);
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

endmodule
